// File: rtl/fc_layer_sequencer_if.sv
// Signal bundle between fc_layer_sequencer and its environment: the start and
// input-vector capture, the weight-ROM/MAC datapath controls, and the result stream.
// The master modport is the sequencer side. The slave modport is the side that
// drives starts, returns MAC results and consumes outputs.
interface fc_layer_sequencer_if #(
  parameter int unsigned ADDR_W = 4
);
  logic                i_start;
  logic [159:0]        i_data;
  logic                o_busy;
  logic [ADDR_W-1:0]   o_w_addr;
  logic                o_w_load;
  logic [159:0]        o_fc_data;
  logic                o_fc_enable;
  logic [31:0]         i_fc_result;
  logic                o_out_valid;
  logic                i_out_ready;
  logic [31:0]         o_out_data;
  logic [ADDR_W-1:0]   o_out_idx;
  logic                o_done;

  modport master (
    input  i_start, i_data, i_fc_result, i_out_ready,
    output o_busy, o_w_addr, o_w_load, o_fc_data, o_fc_enable,
    output o_out_valid, o_out_data, o_out_idx, o_done
  );

  modport slave (
    output i_start, i_data, i_fc_result, i_out_ready,
    input  o_busy, o_w_addr, o_w_load, o_fc_data, o_fc_enable,
    input  o_out_valid, o_out_data, o_out_idx, o_done
  );
endinterface

// File: rtl/fc_layer_sequencer.sv
// Fully-connected layer sequencer. It latches one 16x10-bit input vector and walks
// N_OUT neurons through the single-neuron MAC datapath. For each neuron it fetches
// the weight row, loads it, fires the MAC, waits MAC_LAT cycles and then streams the
// 32-bit result over a valid/ready port.
// Optional feature: define FC_SEQ_RELU_EN to clamp negative results to zero at capture.
module fc_layer_sequencer #(
  parameter int unsigned N_OUT   = 10,
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned MAC_LAT = 1
) (
  input logic                  i_clk,
  input logic                  i_reset,
  fc_layer_sequencer_if.master bus
);

  localparam logic [ADDR_W-1:0] LastIdx  = ADDR_W'(N_OUT - 1);
  localparam logic [2:0]        WaitInit = 3'(MAC_LAT);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLoad,
    StCompute,
    StWait,
    StEmit,
    StDone
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic [2:0]        wait_q;
  logic [31:0]       result_cap;

  // Value captured from the datapath in the final WAIT cycle.
  always_comb begin
    result_cap = bus.i_fc_result;
`ifdef FC_SEQ_RELU_EN
    if (bus.i_fc_result[31]) result_cap = '0;
`endif
  end

  // Sequencer FSM. Every output is registered here, so pulses line up with the
  // state that owns them.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q         <= StIdle;
      cnt_q           <= '0;
      wait_q          <= '0;
      bus.o_busy      <= 1'b0;
      bus.o_w_addr    <= '0;
      bus.o_w_load    <= 1'b0;
      bus.o_fc_data   <= '0;
      bus.o_fc_enable <= 1'b0;
      bus.o_out_valid <= 1'b0;
      bus.o_out_data  <= '0;
      bus.o_out_idx   <= '0;
      bus.o_done      <= 1'b0;
    end else begin
      bus.o_w_load    <= 1'b0;
      bus.o_fc_enable <= 1'b0;
      bus.o_done      <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.i_start) begin
            bus.o_fc_data <= bus.i_data;
            cnt_q         <= '0;
            bus.o_w_addr  <= '0;
            bus.o_busy    <= 1'b1;
            state_q       <= StFetch;
          end
        end
        // ROM row addressed this cycle; its data is valid during LOAD.
        StFetch: begin
          bus.o_w_load <= 1'b1;
          state_q      <= StLoad;
        end
        StLoad: begin
          bus.o_fc_enable <= 1'b1;
          state_q         <= StCompute;
        end
        StCompute: begin
          wait_q  <= WaitInit;
          state_q <= StWait;
        end
        StWait: begin
          if (wait_q == 3'd1) begin
            bus.o_out_data  <= result_cap;
            bus.o_out_idx   <= cnt_q;
            bus.o_out_valid <= 1'b1;
            state_q         <= StEmit;
          end else begin
            wait_q <= wait_q - 3'd1;
          end
        end
        // Result and index are held until the consumer takes them.
        StEmit: begin
          if (bus.i_out_ready) begin
            bus.o_out_valid <= 1'b0;
            if (cnt_q == LastIdx) begin
              bus.o_done <= 1'b1;
              state_q    <= StDone;
            end else begin
              cnt_q        <= cnt_q + ADDR_W'(1);
              bus.o_w_addr <= cnt_q + ADDR_W'(1);
              state_q      <= StFetch;
            end
          end
        end
        StDone: begin
          bus.o_busy <= 1'b0;
          state_q    <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
